// File: rtl/gpp_pkg.sv
// Constants shared by the program-memory responder and the GPP decoder:
// store geometry, responder FSM encoding and instruction field widths.
package gpp_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;
    localparam int DW    = 32;

    localparam int OP_W = 6;
    localparam int RS_W = 5;
    localparam int RT_W = 5;
    localparam int RD_W = 5;
    localparam int SH_W = 5;
    localparam int FN_W = 6;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/prog_mem_responder_byte_packer.sv
// Big-endian byte-to-word packer: bytes land MSB first, an early last byte
// leaves the remaining low bytes zero, and word_valid pulses with the completing byte.
module byte_packer
    import gpp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic [DW-1:0] word,
    output logic          word_valid
);

    logic [DW-1:0] pack_reg, pack_next;
    logic [1:0]    cnt_reg, cnt_next;

    // Each byte is OR-ed into its final lane, so unfilled lanes stay zero.
    always_comb begin
        word       = pack_reg | ({24'd0, ld_byte} << {~cnt_reg, 3'b000});
        word_valid = ld_valid && ((cnt_reg == 2'd3) || ld_last);
        pack_next  = pack_reg;
        cnt_next   = cnt_reg;
        if (clr || word_valid) begin
            pack_next = '0;
            cnt_next  = 2'd0;
        end else if (ld_valid) begin
            pack_next = word;
            cnt_next  = cnt_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg <= '0;
            cnt_reg  <= 2'd0;
        end else begin
            pack_reg <= pack_next;
            cnt_reg  <= cnt_next;
        end
    end

endmodule

// File: rtl/prog_mem_responder.sv
// 16x32 program store loaded from a byte stream and served to the GPP fetch port.
// Define PMEM_CHECKSUM_EN to treat the final stream word as a sum-of-words checksum.
module prog_mem_responder
    import gpp_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic [AW-1:0] Addr,
    input  logic          RW,
    input  logic          En,
    output logic [DW-1:0] Data,
    input  logic          LdValid,
    input  logic [7:0]    LdByte,
    input  logic          LdLast,
    output logic          LdReady,
    input  logic          Reload,
    output logic          Loaded,
    output logic [CW-1:0] WordCnt,
    output logic          Err
);

    state_t        state_reg, state_next;
    logic [CW-1:0] word_cnt_reg, word_cnt_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic [DW-1:0] data_reg, data_next;
    logic [DW-1:0] mem [DEPTH];

    logic          accept, loading, fetch, wr_req, wr_en, ck_bad, finishing;
    logic [DW-1:0] pk_word;
    logic          pk_valid;

`ifdef PMEM_CHECKSUM_EN
    logic [DW-1:0] sum_reg, sum_next;
    logic          ck_word;
`endif

    byte_packer u_packer (
        .clk        (Clk),
        .rst_n      (Rst),
        .clr        (Reload),
        .ld_valid   (accept),
        .ld_byte    (LdByte),
        .ld_last    (LdLast),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_reg <= S_LOAD;
        else      state_reg <= state_next;
    end

    // done_reg delays the hand-over by one edge so Loaded follows the final write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD:  if (!Reload && done_reg) state_next = S_READY;
            S_READY: if (Reload)              state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    always_comb begin
        Loaded  = (state_reg == S_READY);
        LdReady = (state_reg == S_LOAD) && !done_reg;
    end

    always_comb begin
        loading   = (state_reg == S_LOAD);
        fetch     = En && !RW;
        wr_req    = En && RW;
        accept    = LdValid && LdReady && !Reload;
        wr_en     = pk_valid;
        ck_bad    = 1'b0;
        finishing = pk_valid && (LdLast || (word_cnt_reg == CW'(DEPTH - 1)));
`ifdef PMEM_CHECKSUM_EN
        // The checksum word is the one carrying LdLast, or the word after a full store.
        ck_word   = pk_valid && (LdLast || (word_cnt_reg == CW'(DEPTH)));
        wr_en     = pk_valid && !ck_word;
        ck_bad    = ck_word && (pk_word != sum_reg);
        finishing = ck_word;
        sum_next  = Reload ? '0 : (wr_en ? sum_reg + pk_word : sum_reg);
`endif
        word_cnt_next = Reload ? '0 : (wr_en ? word_cnt_reg + CW'(1) : word_cnt_reg);
        done_next     = Reload ? 1'b0 : (done_reg || finishing);
        err_next      = Reload ? 1'b0 : (err_reg || (fetch && loading) || wr_req || ck_bad);
        data_next     = data_reg;
        if (fetch) data_next = loading ? '0 : mem[Addr];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            word_cnt_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            data_reg     <= '0;
`ifdef PMEM_CHECKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            word_cnt_reg <= word_cnt_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            data_reg     <= data_next;
`ifdef PMEM_CHECKSUM_EN
            sum_reg      <= sum_next;
`endif
        end
    end

    // Reload deliberately leaves the store intact; only reset clears it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[word_cnt_reg[AW-1:0]] <= pk_word;
        end
    end

    assign Data    = data_reg;
    assign WordCnt = word_cnt_reg;
    assign Err     = err_reg;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed/randomized bench for prog_mem_responder with a byte-stream reference model.
module tb_prog_mem_responder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [3:0]  Addr = '0;
    logic        RW = 1'b0;
    logic        En = 1'b0;
    logic [31:0] Data;
    logic        LdValid = 1'b0;
    logic [7:0]  LdByte = '0;
    logic        LdLast = 1'b0;
    logic        LdReady;
    logic        Reload = 1'b0;
    logic        Loaded;
    logic [4:0]  WordCnt;
    logic        Err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [16];
    logic [7:0]  preset [$];
    int          acc;
    logic [3:0]  a;

    prog_mem_responder dut (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .RW(RW), .En(En), .Data(Data),
        .LdValid(LdValid), .LdByte(LdByte), .LdLast(LdLast), .LdReady(LdReady),
        .Reload(Reload), .Loaded(Loaded), .WordCnt(WordCnt), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive n bytes (preset first, then random); bytes offered while LdReady is
    // low are dropped. The model rebuilds stored words from the accepted bytes.
    task automatic load_stream(input int n, input bit with_last, output int accepted);
        logic [7:0]  q [$];
        logic [31:0] w;
        int          nw;
        accepted = 0;
        for (int k = 0; k < n; k++) begin
            LdValid = 1'b1;
            LdByte  = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
            LdLast  = with_last && (k == n - 1);
            if (LdReady) begin
                q.push_back(LdByte);
                accepted++;
            end
            tick();
        end
        LdValid = 1'b0;
        LdLast  = 1'b0;
        nw = (q.size() + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * wi + j < q.size()) w = w | (32'(q[4 * wi + j]) << (24 - 8 * j));
            ref_mem[wi] = w;
        end
        $display("[TB] load bytes=%0d accepted=%0d words=%0d", n, accepted, nw);
    endtask

    task automatic fetch(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        Addr = addr;
        En   = 1'b1;
        RW   = 1'b0;
        tick();
        En   = 1'b0;
        $display("[TB] fetch addr=%0d data=%h", addr, Data);
        check(tag, Data, exp);
    endtask

    task automatic pulse_reload();
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        #2 Rst = 1'b0;
        tick();
        check("rst_data", Data, 32'h0);
        check("rst_ldready", 32'(LdReady), 32'd1);
        check("rst_loaded", 32'(Loaded), 32'd0);
        check("rst_wordcnt", 32'(WordCnt), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        Rst = 1'b1;
        tick();

`ifdef PMEM_CHECKSUM_EN
        preset = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h00, 8'h00, 8'h00, 8'h03};
        load_stream(12, 1'b1, acc);
        tick();
        check("ck_good_err", 32'(Err), 32'd0);
        check("ck_good_cnt", 32'(WordCnt), 32'd2);
        check("ck_good_loaded", 32'(Loaded), 32'd1);
        fetch(4'd1, 32'h2, "ck_fetch1");
        pulse_reload();
        preset = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                  8'h00, 8'h00, 8'h00, 8'h04};
        load_stream(12, 1'b1, acc);
        tick();
        check("ck_bad_err", 32'(Err), 32'd1);
        check("ck_bad_loaded", 32'(Loaded), 32'd1);
        check("ck_bad_cnt", 32'(WordCnt), 32'd2);
        fetch(4'd0, 32'h1, "ck_fetch0");
`else
        // Nine-word program, LdLast on byte 36.
        preset = {8'h20, 8'h01, 8'h00, 8'h05};
        load_stream(36, 1'b1, acc);
        check("load9_cnt", 32'(WordCnt), 32'd9);
        tick();
        check("load9_loaded", 32'(Loaded), 32'd1);
        check("load9_ldready", 32'(LdReady), 32'd0);
        check("load9_err", 32'(Err), 32'd0);
        fetch(4'd0, 32'h2001_0005, "fetch_word0");
        tick();
        check("data_hold", Data, 32'h2001_0005);
        for (int i = 0; i < 12; i++) begin
            a = 4'($urandom_range(15, 0));
            fetch(a, ref_mem[a], "fetch_rand9");
        end

        // GPP-side write is rejected and flagged.
        Addr = 4'd3; En = 1'b1; RW = 1'b1;
        tick();
        En = 1'b0; RW = 1'b0;
        check("wr_ready_err", 32'(Err), 32'd1);
        fetch(4'd3, ref_mem[3], "wr_ready_nomod");

        // Reload then a short load ending on byte 2 of word 1.
        pulse_reload();
        check("reload_err", 32'(Err), 32'd0);
        check("reload_cnt", 32'(WordCnt), 32'd0);
        check("reload_loaded", 32'(Loaded), 32'd0);
        check("reload_ldready", 32'(LdReady), 32'd1);
        preset = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'hAB, 8'hCD};
        load_stream(6, 1'b1, acc);
        check("short_cnt", 32'(WordCnt), 32'd2);
        tick();
        fetch(4'd1, 32'hABCD_0000, "short_pad");
        for (int i = 0; i < 9; i++) fetch(4'(i), ref_mem[i], "retain");

        // Fetch and write while loading.
        pulse_reload();
        fetch(4'd0, 32'h0, "fetch_load_data");
        check("fetch_load_err", 32'(Err), 32'd1);
        Addr = 4'd7; En = 1'b1; RW = 1'b1;
        tick();
        En = 1'b0; RW = 1'b0;
        check("wr_load_err", 32'(Err), 32'd1);

        // 70 bytes with no LdLast: auto-stop at 16 words.
        load_stream(70, 1'b0, acc);
        check("full_accepted", 32'(acc), 32'd64);
        check("full_cnt", 32'(WordCnt), 32'd16);
        check("full_ldready", 32'(LdReady), 32'd0);
        check("full_loaded", 32'(Loaded), 32'd1);
        check("full_err_sticky", 32'(Err), 32'd1);
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(15, 0));
            fetch(a, ref_mem[a], "fetch_rand16");
        end

        // Reload with a fetch on the same edge returns old content.
        Addr = 4'd5; En = 1'b1; RW = 1'b0; Reload = 1'b1;
        tick();
        En = 1'b0; Reload = 1'b0;
        check("reload_fetch_data", Data, ref_mem[5]);
        check("reload_fetch_loaded", 32'(Loaded), 32'd0);
`endif

        // Asynchronous reset in the middle of a load.
        load_stream(5, 1'b0, acc);
        Rst = 1'b0;
        #1;
        check("async_cnt", 32'(WordCnt), 32'd0);
        check("async_data", Data, 32'h0);
        check("async_loaded", 32'(Loaded), 32'd0);
        Rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
